log_dump_reader: RTL and testbench

//   Downstream consumer of the BRAM sample logger. When the logger reports full and a dump is

---
 rtl/log_dump_reader_pkg.sv | 33 +++
 rtl/log_dump_reader_if.sv | 33 +++
 rtl/log_dump_reader_word_byte_serializer.sv | 66 ++++++
 rtl/log_dump_reader.sv | 127 ++++++++++++
 tb/tb_log_dump_reader.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/log_dump_reader_pkg.sv
// Shared definitions for the log dump reader: FSM encoding and width helpers.
package log_dump_reader_pkg;

    // Dump sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_NEXT = 3'd4
    } state_t;

    // Number of bits needed to hold value (0 for value==0); same helper the logger uses.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned v;
        int unsigned n;
        v = value;
        n = 0;
        while (v > 0) begin
            n = n + 1;
            v = v >> 1;
        end
        return n;
    endfunction

    // Width for a counter reaching max_val, never narrower than one bit.
    function automatic int unsigned bits_for(input int unsigned max_val);
        int unsigned n;
        n = clogb2(max_val);
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/log_dump_reader_if.sv
// Logger read port plus UART TX byte stream as seen by the dump reader.
interface log_dump_reader_if #(
    parameter int unsigned RAM_WIDTH = 32,
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned NB_BYTE   = 8
);
    logic                 o_read_log;
    logic [ADDR_W-1:0]    o_addr_log;
    logic [RAM_WIDTH-1:0] i_data_log;
    logic [NB_BYTE-1:0]   o_tx_data;
    logic                 o_tx_valid;
    logic                 i_tx_ready;

    // Dump reader side.
    modport master (
        output o_read_log,
        output o_addr_log,
        input  i_data_log,
        output o_tx_data,
        output o_tx_valid,
        input  i_tx_ready
    );

    // Logger / UART side.
    modport slave (
        input  o_read_log,
        input  o_addr_log,
        output i_data_log,
        input  o_tx_data,
        input  o_tx_valid,
        output i_tx_ready
    );
endinterface

// File: rtl/log_dump_reader_word_byte_serializer.sv
// Holds one logged word and presents it LSB byte first on a valid/ready stream.
module log_dump_reader_word_byte_serializer
    import log_dump_reader_pkg::*;
#(
    parameter int unsigned RAM_WIDTH = 32,
    parameter int unsigned NB_BYTE   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 clear,
    input  logic [RAM_WIDTH-1:0] word,
    input  logic                 tx_ready,
    output logic [NB_BYTE-1:0]   tx_data,
    output logic                 tx_valid,
    output logic                 last_xfer_c
);
    localparam int unsigned NBYTES = RAM_WIDTH / NB_BYTE;
    localparam int unsigned IDX_W  = bits_for(NBYTES - 1);

    logic [RAM_WIDTH-1:0] word_q;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     idx_nxt;
    logic [NB_BYTE-1:0]   data_q;
    logic                 valid_q;
    logic                 xfer_c;
    logic                 last_idx_c;

    // Handshake decode and next byte index.
    always_comb begin
        xfer_c      = valid_q & tx_ready;
        last_idx_c  = (idx_q == IDX_W'(NBYTES - 1));
        last_xfer_c = xfer_c & last_idx_c;
        idx_nxt     = idx_q + IDX_W'(1);
    end

    // Word load, byte stepping and valid hold; clear discards a partly sent word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (clear) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            word_q  <= word;
            idx_q   <= '0;
            data_q  <= word[NB_BYTE-1:0];
            valid_q <= 1'b1;
        end else if (xfer_c) begin
            if (last_idx_c) begin
                idx_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                idx_q  <= idx_nxt;
                data_q <= word_q[NB_BYTE * 32'(idx_nxt) +: NB_BYTE];
            end
        end
    end

    assign tx_data  = data_q;
    assign tx_valid = valid_q;

endmodule

// File: rtl/log_dump_reader.sv
// Walks the full logger RAM after a dump request and streams every word out as bytes.
module log_dump_reader
    import log_dump_reader_pkg::*;
#(
    parameter int unsigned RAM_WIDTH    = 32,
    parameter int unsigned RAM_DEPTH    = 2**15,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned NB_BYTE      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start_dump,
    input  logic                i_mem_full,
    output logic                o_busy,
    output logic                o_done,
    log_dump_reader_if.master   bus
);
    localparam int unsigned ADDR_W = bits_for(RAM_DEPTH - 1);
    localparam int unsigned LAT_W  = bits_for(READ_LATENCY);

    state_t              state_q;
    state_t              state_n;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_n;
    logic [LAT_W-1:0]    lat_q;
    logic [LAT_W-1:0]    lat_n;
    logic                read_q;
    logic                busy_q;
    logic                done_q;
    logic                load_c;
    logic                clear_c;
    logic                done_c;
    logic                last_xfer_c;

    // Next-state, address and latency counter; an empty logger aborts from any busy state.
    always_comb begin
        state_n = state_q;
        addr_n  = addr_q;
        lat_n   = lat_q;
        load_c  = 1'b0;
        clear_c = 1'b0;
        done_c  = 1'b0;
        if ((state_q != ST_IDLE) && !i_mem_full) begin
            state_n = ST_IDLE;
            clear_c = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start_dump && i_mem_full) begin
                        state_n = ST_REQ;
                        addr_n  = '0;
                    end
                end
                ST_REQ: begin
                    state_n = ST_WAIT;
                    lat_n   = '0;
                end
                ST_WAIT: begin
                    if (lat_q == LAT_W'(READ_LATENCY - 1)) begin
                        load_c  = 1'b1;
                        state_n = ST_SEND;
                    end else begin
                        lat_n = lat_q + LAT_W'(1);
                    end
                end
                ST_SEND: begin
                    if (last_xfer_c) begin
                        state_n = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (addr_q == ADDR_W'(RAM_DEPTH - 1)) begin
                        state_n = ST_IDLE;
                        done_c  = 1'b1;
                    end else begin
                        addr_n  = addr_q + ADDR_W'(1);
                        state_n = ST_REQ;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    clear_c = 1'b1;
                end
            endcase
        end
    end

    // State, counters and registered control outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            lat_q   <= '0;
            read_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            addr_q  <= addr_n;
            lat_q   <= lat_n;
            read_q  <= (state_n == ST_REQ);
            busy_q  <= (state_n != ST_IDLE);
            done_q  <= done_c;
        end
    end

    log_dump_reader_word_byte_serializer #(
        .RAM_WIDTH (RAM_WIDTH),
        .NB_BYTE   (NB_BYTE)
    ) u_ser (
        .clk         (clk),
        .reset       (reset),
        .load        (load_c),
        .clear       (clear_c),
        .word        (bus.i_data_log),
        .tx_ready    (bus.i_tx_ready),
        .tx_data     (bus.o_tx_data),
        .tx_valid    (bus.o_tx_valid),
        .last_xfer_c (last_xfer_c)
    );

    assign bus.o_read_log = read_q;
    assign bus.o_addr_log = addr_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;

endmodule

// File: tb/tb_log_dump_reader.sv
// Scoreboard bench for log_dump_reader with a small latency-2 logger model.
module tb_log_dump_reader;
    import log_dump_reader_pkg::*;

    localparam int unsigned RAM_WIDTH    = 32;
    localparam int unsigned RAM_DEPTH    = 4;
    localparam int unsigned READ_LATENCY = 2;
    localparam int unsigned NB_BYTE      = 8;
    localparam int unsigned ADDR_W       = 2;
    localparam int unsigned NBYTES       = 4;
    // Start-edge to o_done: one IDLE->REQ edge + 4 words * (1 + 2 + 4 + 1) clocks.
    localparam int          DUMP_CYCLES  = 33;

    logic clk;
    logic reset;
    logic i_start_dump;
    logic i_mem_full;
    logic o_busy;
    logic o_done;

    log_dump_reader_if #(.RAM_WIDTH(RAM_WIDTH), .ADDR_W(ADDR_W), .NB_BYTE(NB_BYTE)) bus ();

    log_dump_reader #(
        .RAM_WIDTH    (RAM_WIDTH),
        .RAM_DEPTH    (RAM_DEPTH),
        .READ_LATENCY (READ_LATENCY),
        .NB_BYTE      (NB_BYTE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start_dump (i_start_dump),
        .i_mem_full   (i_mem_full),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_reads = 0;
    int n_bytes = 0;
    int n_done  = 0;
    int mode    = 0;
    int cyc_r   = 0;

    logic [7:0]  exp_q[$];
    int          exp_addr_q[$];
    logic [31:0] mem [RAM_DEPTH];
    logic [31:0] p1;
    logic [31:0] p2;
    logic [7:0]  base_bytes [NBYTES];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Logger model: two-stage read pipeline; poison when no read is issued.
    always @(posedge clk) begin
        p1 <= bus.o_read_log ? mem[bus.o_addr_log] : 32'hDEADBEEF;
        p2 <= p1;
    end
    assign bus.i_data_log = p2;

    // UART ready driver: 0 = always ready, 1 = ready one cycle in three, 2 = stalled.
    initial begin
        bus.i_tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc_r++;
            case (mode)
                0: bus.i_tx_ready = 1'b1;
                1: bus.i_tx_ready = ((cyc_r % 3) == 0);
                default: bus.i_tx_ready = 1'b0;
            endcase
        end
    end

    // Monitor: read addresses, bytes (and their hold while stalled) and done pulses.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.o_read_log) begin
                n_reads++;
                if (exp_addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL read_unexpected: got addr %0d expected no read", bus.o_addr_log);
                end else begin
                    check("read_addr", longint'(bus.o_addr_log), longint'(exp_addr_q.pop_front()));
                end
            end
            if (bus.o_tx_valid) begin
                if (bus.i_tx_ready) n_bytes++;
                if (exp_q.size() == 0) begin
                    if (bus.i_tx_ready) begin
                        total++;
                        bad++;
                        $display("FAIL byte_unexpected: got %0h expected none", bus.o_tx_data);
                    end
                end else if (bus.i_tx_ready) begin
                    check("tx_byte", longint'(bus.o_tx_data), longint'(exp_q.pop_front()));
                end else begin
                    check("tx_hold", longint'(bus.o_tx_data), longint'(exp_q[0]));
                end
            end
            if (o_done) begin
                n_done++;
                check("busy_at_done", longint'(o_busy), 0);
                check("bytes_left_at_done", longint'(exp_q.size()), 0);
            end
        end
    end

    task automatic push_word(input int w, input int nb);
        for (int b = 0; b < nb; b++) begin
            exp_q.push_back((b == 0) ? base_bytes[b] + 8'(w) : base_bytes[b]);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 i_start_dump = 1'b1;
        @(posedge clk);
        #1 i_start_dump = 1'b0;
    endtask

    task automatic run_dump(input string name, input int rmode, input int max_cyc, input bit chk_lat);
        int cyc;
        int d0;
        mode = rmode;
        repeat (2) @(posedge clk);
        for (int w = 0; w < int'(RAM_DEPTH); w++) begin
            exp_addr_q.push_back(w);
            push_word(w, NBYTES);
        end
        d0 = n_done;
        pulse_start();
        cyc = 0;
        while ((n_done == d0) && (cyc < max_cyc)) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (n_done == d0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no o_done expected one within %0d cycles", name, max_cyc);
        end else if (chk_lat) begin
            check({name, "_cycles"}, cyc, DUMP_CYCLES);
        end
        repeat (3) @(negedge clk);
        #1;
        check({name, "_done_count"}, n_done - d0, 1);
        check({name, "_bytes_left"}, longint'(exp_q.size()), 0);
        check({name, "_addr_left"}, longint'(exp_addr_q.size()), 0);
        check({name, "_busy_after"}, longint'(o_busy), 0);
        exp_q.delete();
        exp_addr_q.delete();
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_read"},  longint'(bus.o_read_log), 0);
        check({name, "_addr"},  longint'(bus.o_addr_log), 0);
        check({name, "_data"},  longint'(bus.o_tx_data), 0);
        check({name, "_valid"}, longint'(bus.o_tx_valid), 0);
        check({name, "_busy"},  longint'(o_busy), 0);
        check({name, "_done"},  longint'(o_done), 0);
    endtask

    initial begin
        int cyc;
        int base;
        int saved;
        base_bytes[0] = 8'hD0;
        base_bytes[1] = 8'hC0;
        base_bytes[2] = 8'hB0;
        base_bytes[3] = 8'hA0;
        for (int i = 0; i < int'(RAM_DEPTH); i++) mem[i] = 32'hA0B0C0D0 + 32'(i);
        reset        = 1'b1;
        i_start_dump = 1'b0;
        i_mem_full   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Full dump with ready held high.
        i_mem_full = 1'b1;
        run_dump("dump_ready", 0, 200, 1'b1);

        // Same dump under 1-in-3 backpressure.
        run_dump("dump_bp", 1, 600, 1'b0);

        // Start while the logger is not full is ignored.
        mode = 0;
        i_mem_full = 1'b0;
        saved = n_reads;
        pulse_start();
        repeat (10) @(negedge clk);
        #1;
        check("notfull_busy", longint'(o_busy), 0);
        check("notfull_reads", n_reads, saved);

        // Abort after five bytes: full drops, sixth byte is stalled then discarded.
        i_mem_full = 1'b1;
        repeat (2) @(posedge clk);
        exp_addr_q.push_back(0);
        exp_addr_q.push_back(1);
        push_word(0, 4);
        push_word(1, 2);
        base = n_bytes;
        saved = n_done;
        pulse_start();
        cyc = 0;
        while ((n_bytes != base + 5) && (cyc < 100)) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("abort_reached_5", n_bytes - base, 5);
        mode = 2;
        @(posedge clk);
        #1 i_mem_full = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("abort_valid", longint'(bus.o_tx_valid), 0);
        check("abort_busy", longint'(o_busy), 0);
        check("abort_bytes_pending", longint'(exp_q.size()), 1);
        repeat (5) @(negedge clk);
        #1;
        check("abort_no_done", n_done, saved);
        check("abort_addr_left", longint'(exp_addr_q.size()), 0);
        exp_q.delete();
        exp_addr_q.delete();
        i_mem_full = 1'b1;
        run_dump("restart", 0, 200, 1'b1);

        // Asynchronous reset in the middle of a word.
        mode = 0;
        repeat (2) @(posedge clk);
        exp_addr_q.push_back(0);
        push_word(0, 4);
        base = n_bytes;
        pulse_start();
        cyc = 0;
        while ((n_bytes != base + 2) && (cyc < 100)) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("midreset_reached_2", n_bytes - base, 2);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        exp_q.delete();
        exp_addr_q.delete();
        @(negedge clk);
        reset = 1'b0;
        run_dump("after_reset", 0, 200, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
